// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   NCH_DEF     default number of divider channels
//   DIV_W_DEF   default divide-ratio field width
//   DIV_RST_DEF ratio loaded into every channel at reset (40 MHz -> 2 MHz)
//   DIV_MIN     smallest legal ratio; smaller requests are clamped to it
//   ch_idx_w()  width of a channel index, never less than one bit
package clkdiv_pkg;

    localparam int NCH_DEF     = 4;
    localparam int DIV_W_DEF   = 8;
    localparam int DIV_RST_DEF = 20;
    localparam int DIV_MIN     = 2;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter over 0..D-1, active and pending ratio, and
// registered clk_out / tick outputs.
// Optional feature macro: CLKDIV_PHASE_SYNC_EN adds sync_i (restart counter).
// Ports:
//   clock      source clock
//   rst        asynchronous active-high reset
//   en_i       run enable
//   sync_i     phase-alignment request (CLKDIV_PHASE_SYNC_EN only)
//   load_i     an accepted ratio for this channel is presented on div_i
//   div_i      already-clamped ratio
//   pending_o  a ratio is waiting for the next period boundary
//   clk_out_o  divided clock (high while cnt < D/2)
//   tick_o     high in the cycle where cnt == 0
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en_i,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             pending_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic             run_q, run_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             restart;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign restart = sync_i;
`else
    assign restart = 1'b0;
`endif

    assign wrap = (cnt_q == act_q - DIV_W'(1));

    always_comb begin
        run_d    = en_i;
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (run_q && en_i) begin
            // Running: a new ratio waits for the period boundary so no runt
            // pulse is produced. A load in the wrap cycle re-arms pending.
            cnt_d = (wrap || restart) ? '0 : cnt_q + DIV_W'(1);
            if (wrap && pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end
            if (load_i) begin
                pend_d   = div_i;
                pend_v_d = 1'b1;
            end
        end else begin
            // Stopped or just starting: nothing to protect, apply at once.
            cnt_d = '0;
            if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end
            if (load_i) begin
                act_d = div_i;
            end
        end
        clk_d  = run_d && (cnt_d < (act_d >> 1));
        tick_d = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            act_q    <= DIV_W'(DIV_RST);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign pending_o = pend_v_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider with a valid/ready ratio port.
// Optional feature macro: CLKDIV_PHASE_SYNC_EN adds the sync input, which
// restarts every enabled channel at cnt=0 on the next cycle.
// Ports:
//   clock      single source clock
//   rst        asynchronous active-high reset
//   ch_en      per-channel run enable
//   cfg_valid  configuration request
//   cfg_ch     target channel (out-of-range indices are accepted and dropped)
//   cfg_div    requested ratio (values below 2 are clamped to 2)
//   cfg_ready  high when the addressed channel has no pending ratio
//   clk_out    registered divided clocks
//   tick       one-cycle pulse at the start of each output period
//   sync       phase-alignment request (CLKDIV_PHASE_SYNC_EN only)
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [NCH-1:0]              ch_en,
    input  logic                        cfg_valid,
    input  logic [ch_idx_w(NCH)-1:0]    cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic                        cfg_ready,
    output logic [NCH-1:0]              clk_out,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic                        sync,
`endif
    output logic [NCH-1:0]              tick
);

    localparam int CH_W = ch_idx_w(NCH);

    logic             in_range;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   load;
    logic [DIV_W-1:0] div_clamped;

    // When NCH fills the index space every index is valid.
    if ((1 << CH_W) > NCH) begin : g_range_chk
        assign in_range = (cfg_ch < CH_W'(NCH));
    end else begin : g_range_all
        assign in_range = 1'b1;
    end

    assign div_clamped = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;

    always_comb begin
        cfg_ready = 1'b1;
        if (in_range) begin
            cfg_ready = !pending[cfg_ch];
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign load[i] = cfg_valid && cfg_ready && in_range && (cfg_ch == CH_W'(i));

        clkdiv_channel #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clock     (clock),
            .rst       (rst),
            .en_i      (ch_en[i]),
`ifdef CLKDIV_PHASE_SYNC_EN
            .sync_i    (sync),
`endif
            .load_i    (load[i]),
            .div_i     (div_clamped),
            .pending_o (pending[i]),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ch_en = '0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_ready;
    logic [3:0] clk_out, tick;
    logic       cfg_ready3;
    logic [2:0] clk_out3, tick3;
`ifdef CLKDIV_PHASE_SYNC_EN
    logic       sync = 1'b0;
`endif

    always #5 clock = ~clock;

    clock_divider_prog dut (
        .clock     (clock),
        .rst       (rst),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync      (sync),
`endif
        .tick      (tick)
    );

    // Three-channel instance so that an out-of-range cfg_ch (3) exists.
    clock_divider_prog #(.NCH(3)) dut3 (
        .clock     (clock),
        .rst       (rst),
        .ch_en     (ch_en[2:0]),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready3),
        .clk_out   (clk_out3),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync      (sync),
`endif
        .tick      (tick3)
    );

    typedef struct packed {
        logic [3:0] clk;
        logic [3:0] tck;
        logic       rdy;
        logic [2:0] clk3;
        logic [2:0] tck3;
        logic       rdy3;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference model: per unit (0: 4 channels, 1: 3 channels) each channel
    // has a position within its period, the ratio in force, and a waiting
    // ratio (0 = none).
    int m_run[2][4];
    int m_pos[2][4];
    int m_ratio[2][4];
    int m_pend[2][4];

    function automatic int nch(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    function automatic void m_reset();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 4; i++) begin
                m_run[u][i] = 0; m_pos[u][i] = 0; m_ratio[u][i] = 20; m_pend[u][i] = 0;
            end
    endfunction

    function automatic bit m_ready(input int u, input int ch);
        if (ch >= nch(u)) return 1'b1;
        return m_pend[u][ch] == 0;
    endfunction

    function automatic exp_t m_expect(input int ch);
        exp_t e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e.clk[i] = (m_run[0][i] != 0) && (m_pos[0][i] < m_ratio[0][i] / 2);
            e.tck[i] = (m_run[0][i] != 0) && (m_pos[0][i] == 0);
        end
        for (int i = 0; i < 3; i++) begin
            e.clk3[i] = (m_run[1][i] != 0) && (m_pos[1][i] < m_ratio[1][i] / 2);
            e.tck3[i] = (m_run[1][i] != 0) && (m_pos[1][i] == 0);
        end
        e.rdy  = m_ready(0, ch);
        e.rdy3 = m_ready(1, ch);
        return e;
    endfunction

    function automatic void m_advance(input logic [3:0] en, input bit cv, input int ch,
                                      input int div, input bit sy);
        bit acc[2];
        int newr;
        newr = (div < 2) ? 2 : div;
        for (int u = 0; u < 2; u++) acc[u] = cv && m_ready(u, ch);
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < nch(u); i++) begin
                if (m_run[u][i] != 0 && en[i]) begin
                    bit at_end;
                    at_end = (m_pos[u][i] == m_ratio[u][i] - 1);
                    m_pos[u][i] = (at_end || sy) ? 0 : m_pos[u][i] + 1;
                    if (at_end && m_pend[u][i] != 0) begin
                        m_ratio[u][i] = m_pend[u][i];
                        m_pend[u][i] = 0;
                    end
                    if (acc[u] && ch == i) m_pend[u][i] = newr;
                end else begin
                    m_pos[u][i] = 0;
                    if (m_pend[u][i] != 0) begin
                        m_ratio[u][i] = m_pend[u][i];
                        m_pend[u][i] = 0;
                    end
                    if (acc[u] && ch == i) m_ratio[u][i] = newr;
                end
                m_run[u][i] = en[i] ? 1 : 0;
            end
    endfunction

    // Drives one cycle of inputs (shortly after a rising edge), records the
    // expected outputs for the monitor, then advances to the next edge.
    task automatic step(input bit r, input logic [3:0] en, input bit cv, input int ch,
                        input int div, input bit sy, output bit acc0);
        bit sy_eff;
        rst = r; ch_en = en; cfg_valid = cv; cfg_ch = ch[1:0]; cfg_div = div[7:0];
`ifdef CLKDIV_PHASE_SYNC_EN
        sync = sy;
        sy_eff = sy;
`else
        sy_eff = 1'b0;
`endif
        if (r) m_reset();
        acc0 = !r && cv && m_ready(0, ch);
        q.push_back(m_expect(ch));
        if (!r) m_advance(en, cv, ch, div, sy_eff);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [3:0] en, input int n);
        bit a;
        for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 0, 0, 1'b0, a);
    endtask

    task automatic cfg_hold(input logic [3:0] en, input int ch, input int div);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 64 && !a; k++) step(1'b0, en, 1'b1, ch, div, 1'b0, a);
        if (!a) begin
            errors++; checks++;
            $display("FAIL cfg_accept_timeout ch=%0d got no acceptance, wanted one within 64 cycles", ch);
        end
    endtask

    // Monitor: compares what the DUT presents against the queued expectation.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 6;
            if (clk_out !== e.clk) begin
                errors++; $display("FAIL clk_out t=%0t got %b want %b", $time, clk_out, e.clk);
            end
            if (tick !== e.tck) begin
                errors++; $display("FAIL tick t=%0t got %b want %b", $time, tick, e.tck);
            end
            if (cfg_ready !== e.rdy) begin
                errors++; $display("FAIL cfg_ready t=%0t got %b want %b", $time, cfg_ready, e.rdy);
            end
            if (clk_out3 !== e.clk3) begin
                errors++; $display("FAIL clk_out3 t=%0t got %b want %b", $time, clk_out3, e.clk3);
            end
            if (tick3 !== e.tck3) begin
                errors++; $display("FAIL tick3 t=%0t got %b want %b", $time, tick3, e.tck3);
            end
            if (cfg_ready3 !== e.rdy3) begin
                errors++; $display("FAIL cfg_ready3 t=%0t got %b want %b", $time, cfg_ready3, e.rdy3);
            end
        end
    end

    initial begin
        bit a;
        bit found;
        logic [3:0] en;
        m_reset();
        @(posedge clock);
        #1;

        // Reset state.
        for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 1'b0, 0, 0, 1'b0, a);

        // Default ratio on channel 0.
        idle(4'b0001, 45);

        // Ratio change on a running channel, then a second request while pending.
        idle(4'b0011, 25);
        cfg_hold(4'b0011, 1, 7);
        cfg_hold(4'b0011, 1, 5);
        idle(4'b0011, 30);

        // Clamp of 0 and 1; out-of-range index on the three-channel unit.
        cfg_hold(4'b1111, 2, 0);
        cfg_hold(4'b1111, 3, 1);
        cfg_hold(4'b1111, 3, 9);
        idle(4'b1111, 30);

        // Drop ch_en[2] mid-period at position 4, then re-enable.
        cfg_hold(4'b1111, 2, 12);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_pos[0][2] == 4 && m_run[0][2] != 0) found = 1'b1;
            else step(1'b0, 4'b1111, 1'b0, 0, 0, 1'b0, a);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL ch2_pos4_wait got timeout want position 4 reached");
        end
        idle(4'b1011, 3);
        idle(4'b1111, 20);

        // Reset in the middle of a period.
        step(1'b1, 4'b1111, 1'b0, 0, 0, 1'b0, a);
        step(1'b1, 4'b1111, 1'b0, 0, 0, 1'b0, a);
        idle(4'b1111, 10);

        // Ratios 3/5/8/20, then a phase-alignment pulse.
        idle(4'b0000, 2);
        step(1'b0, 4'b0000, 1'b1, 0, 3, 1'b0, a);
        step(1'b0, 4'b0000, 1'b1, 1, 5, 1'b0, a);
        step(1'b0, 4'b0000, 1'b1, 2, 8, 1'b0, a);
        step(1'b0, 4'b0000, 1'b1, 3, 20, 1'b0, a);
        idle(4'b1111, 13);
        step(1'b0, 4'b1111, 1'b0, 0, 0, 1'b1, a);
`ifdef CLKDIV_PHASE_SYNC_EN
        checks++;
        if (tick !== 4'hF) begin
            errors++; $display("FAIL sync_ticks got %b want 1111", tick);
        end
`endif
        idle(4'b1111, 20);

        // Randomized traffic.
        en = 4'b1111;
        for (int k = 0; k < 1500; k++) begin
            bit r, cv, sy;
            int ch, div;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(15) == 0) en[i] = ~en[i];
            r   = ($urandom_range(199) == 0);
            cv  = ($urandom_range(2) == 0);
            ch  = $urandom_range(3);
            div = ($urandom_range(7) == 0) ? $urandom_range(255) : $urandom_range(12);
            sy  = ($urandom_range(49) == 0);
            step(r, en, cv, ch, div, sy, a);
        end

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d left want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
